game_sprite_control: RTL and testbench

Per-sprite motion and position engine; the responder for the game master FSM's sprite strobes (`write_xy`, `write_dxy`, `enable_update`). It loads a position and velocity when strobed, and advances the position on a programmable motion tick while updates are enabled. It reports `within_screen` back to the FSM and a registered pixel-hit flag to the display and collision logic. One instance is used per sprite (target, torpedo).

---
 rtl/game_sprite_control.sv | 102 ++++++++++
 tb/tb_game_sprite_control.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sprite_control.sv
// Per-sprite position/velocity engine: loads on strobes, moves on a
// free-running motion tick, reports on-screen status and a registered pixel hit.
module game_sprite_control #(
    parameter int X_WIDTH          = 10,
    parameter int Y_WIDTH          = 10,
    parameter int DX_WIDTH         = 2,
    parameter int DY_WIDTH         = 2,
    parameter int SCREEN_WIDTH     = 640,
    parameter int SCREEN_HEIGHT    = 480,
    parameter int SPRITE_WIDTH     = 8,
    parameter int SPRITE_HEIGHT    = 8,
    parameter int STROBE_DIV_WIDTH = 22
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sprite_write_xy,
    input  logic                sprite_write_dxy,
    input  logic [X_WIDTH-1:0]  sprite_write_x,
    input  logic [Y_WIDTH-1:0]  sprite_write_y,
    input  logic [DX_WIDTH-1:0] sprite_write_dx,
    input  logic [DY_WIDTH-1:0] sprite_write_dy,
    input  logic                sprite_enable_update,
    input  logic [X_WIDTH-1:0]  pixel_x,
    input  logic [Y_WIDTH-1:0]  pixel_y,
    output logic [X_WIDTH-1:0]  sprite_x,
    output logic [Y_WIDTH-1:0]  sprite_y,
    output logic                sprite_within_screen,
    output logic                sprite_pixel_hit
);

    localparam logic [X_WIDTH-1:0] X_MAX  = X_WIDTH'(SCREEN_WIDTH - SPRITE_WIDTH);
    localparam logic [Y_WIDTH-1:0] Y_MAX  = Y_WIDTH'(SCREEN_HEIGHT - SPRITE_HEIGHT);
    localparam logic [X_WIDTH-1:0] X_SPAN = X_WIDTH'(SPRITE_WIDTH);
    localparam logic [Y_WIDTH-1:0] Y_SPAN = Y_WIDTH'(SPRITE_HEIGHT);

    logic [X_WIDTH-1:0]          x_q, x_d;
    logic [Y_WIDTH-1:0]          y_q, y_d;
    logic [DX_WIDTH-1:0]         dx_q, dx_d;
    logic [DY_WIDTH-1:0]         dy_q, dy_d;
    logic [STROBE_DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                        hit_q, hit_d;

    logic                        tick;
    logic [X_WIDTH-1:0]          dx_ext;
    logic [Y_WIDTH-1:0]          dy_ext;
    logic [X_WIDTH-1:0]          rel_x;
    logic [Y_WIDTH-1:0]          rel_y;

    always_comb begin
        cnt_d  = cnt_q + STROBE_DIV_WIDTH'(1);
        tick   = &cnt_q;
        dx_ext = {{(X_WIDTH - DX_WIDTH){dx_q[DX_WIDTH-1]}}, dx_q};
        dy_ext = {{(Y_WIDTH - DY_WIDTH){dy_q[DY_WIDTH-1]}}, dy_q};

        dx_d = dx_q;
        dy_d = dy_q;
        if (sprite_write_dxy) begin
            dx_d = sprite_write_dx;
            dy_d = sprite_write_dy;
        end

        // Motion uses the old velocity; a load beats a move on the same edge.
        x_d = x_q;
        y_d = y_q;
        if (sprite_write_xy) begin
            x_d = sprite_write_x;
            y_d = sprite_write_y;
        end else if (sprite_enable_update && tick) begin
            x_d = x_q + dx_ext;
            y_d = y_q + dy_ext;
        end

        // Modulo differences make pixels left/above the sprite look huge.
        rel_x = pixel_x - x_q;
        rel_y = pixel_y - y_q;
        hit_d = (rel_x < X_SPAN) && (rel_y < Y_SPAN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
            cnt_q <= '0;
            hit_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            cnt_q <= cnt_d;
            hit_q <= hit_d;
        end
    end

    assign sprite_x             = x_q;
    assign sprite_y             = y_q;
    assign sprite_within_screen = (x_q <= X_MAX) && (y_q <= Y_MAX);
    assign sprite_pixel_hit     = hit_q;

endmodule

// File: tb/tb_game_sprite_control.sv
// Bench for game_sprite_control: directed scenarios plus randomized traffic
// checked against an integer-arithmetic model of sprite motion.
module tb_game_sprite_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wxy = 1'b0, wdxy = 1'b0, en = 1'b0;
    logic [9:0] wx = '0, wy = '0, px = '0, py = '0;
    logic [1:0] wdx = '0, wdy = '0;
    logic [9:0] sprite_x, sprite_y;
    logic       sprite_within_screen, sprite_pixel_hit;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int mx, my, mdx, mdy, nedge;
    bit mhit;

    always #5 clk = ~clk;

    game_sprite_control #(.STROBE_DIV_WIDTH(2)) dut (
        .clk                  (clk),
        .reset                (reset),
        .sprite_write_xy      (wxy),
        .sprite_write_dxy     (wdxy),
        .sprite_write_x       (wx),
        .sprite_write_y       (wy),
        .sprite_write_dx      (wdx),
        .sprite_write_dy      (wdy),
        .sprite_enable_update (en),
        .pixel_x              (px),
        .pixel_y              (py),
        .sprite_x             (sprite_x),
        .sprite_y             (sprite_y),
        .sprite_within_screen (sprite_within_screen),
        .sprite_pixel_hit     (sprite_pixel_hit)
    );

    function automatic int wrap(int v);
        return ((v % 1024) + 1024) % 1024;
    endfunction

    function automatic int sval(logic [1:0] v);
        return v[1] ? int'(v) - 4 : int'(v);
    endfunction

    function automatic bit m_within();
        return (mx <= 640 - 8) && (my <= 480 - 8);
    endfunction

    task automatic model_clear();
        mx = 0; my = 0; mdx = 0; mdy = 0; nedge = 0; mhit = 0;
    endtask

    // One clock edge: advance model with the inputs seen at that edge.
    task automatic step();
        bit tick;
        @(posedge clk);
        nedge++;
        tick = (nedge % 4 == 0);
        mhit = (wrap(int'(px) - mx) < 8) && (wrap(int'(py) - my) < 8);
        if (wxy) begin
            mx = int'(wx); my = int'(wy);
        end else if (en && tick) begin
            mx = wrap(mx + mdx); my = wrap(my + mdy);
        end
        if (wdxy) begin
            mdx = sval(wdx); mdy = sval(wdy);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wxy = 0; wdxy = 0; en = 0;
        #3;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(int x, int y, logic [1:0] dx, logic [1:0] dy);
        wxy = 1; wdxy = 1; wx = 10'(x); wy = 10'(y); wdx = dx; wdy = dy;
        step();
        wxy = 0; wdxy = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (sprite_x !== 0 || sprite_y !== 0) begin
            n_err++;
            $display("FAIL reset_pos: got %0d,%0d want 0,0", sprite_x, sprite_y);
        end
        n_cmp++;
        if (sprite_within_screen !== 1'b1 || sprite_pixel_hit !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got win=%b hit=%b want 1,0",
                     sprite_within_screen, sprite_pixel_hit);
        end
        en = 1; px = 500; py = 400;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (sprite_x !== 0 || sprite_y !== 0 || sprite_within_screen !== 1'b1) begin
                n_err++;
                $display("FAIL idle_pos: got %0d,%0d win=%b want 0,0 win=1",
                         sprite_x, sprite_y, sprite_within_screen);
            end
        end
        en = 0;
    endtask

    task automatic test_motion();
        load(100, 200, 2'b01, 2'b11);
        en = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if (sprite_x !== 10'(mx) || sprite_y !== 10'(my)) begin
                n_err++;
                $display("FAIL motion_step: got %0d,%0d want %0d,%0d",
                         sprite_x, sprite_y, mx, my);
            end
        end
        n_cmp++;
        if (sprite_x !== 103 || sprite_y !== 197) begin
            n_err++;
            $display("FAIL motion_final: got %0d,%0d want 103,197", sprite_x, sprite_y);
        end
        en = 0;
    endtask

    task automatic test_right_edge();
        load(632, 10, 2'b01, 2'b00);
        n_cmp++;
        if (sprite_within_screen !== 1'b1) begin
            n_err++;
            $display("FAIL edge_632: got win=%b want 1", sprite_within_screen);
        end
        en = 1;
        for (int i = 0; i < 8 && sprite_x == 632; i++) step();
        n_cmp++;
        if (sprite_x !== 633 || sprite_within_screen !== 1'b0) begin
            n_err++;
            $display("FAIL edge_633: got x=%0d win=%b want 633 win=0",
                     sprite_x, sprite_within_screen);
        end
        en = 0;
    endtask

    task automatic test_wrap();
        load(0, 5, 2'b11, 2'b00);
        en = 1;
        for (int i = 0; i < 8 && sprite_x == 0; i++) step();
        n_cmp++;
        if (sprite_x !== 1023 || sprite_y !== 5 || sprite_within_screen !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_left: got x=%0d y=%0d win=%b want 1023,5 win=0",
                     sprite_x, sprite_y, sprite_within_screen);
        end
        en = 0;
    endtask

    task automatic test_write_priority();
        load(20, 20, 2'b01, 2'b00);
        en = 1;
        for (int i = 0; i < 4 && (nedge % 4) != 3; i++) step();
        wxy = 1; wx = 50; wy = 50;
        step();
        wxy = 0;
        n_cmp++;
        if (sprite_x !== 50 || sprite_y !== 50 || (nedge % 4) != 0) begin
            n_err++;
            $display("FAIL write_on_tick: got %0d,%0d edge=%0d want 50,50 on tick",
                     sprite_x, sprite_y, nedge);
        end
        en = 0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (sprite_x !== 50) begin
            n_err++;
            $display("FAIL tick_disabled: got x=%0d want 50", sprite_x);
        end
    endtask

    task automatic test_pixel_hit();
        load(300, 100, 2'b00, 2'b00);
        px = 307; py = 107;
        step();
        n_cmp++;
        if (sprite_pixel_hit !== 1'b1) begin
            n_err++;
            $display("FAIL hit_307: got %b want 1", sprite_pixel_hit);
        end
        px = 308;
        step();
        n_cmp++;
        if (sprite_pixel_hit !== 1'b0) begin
            n_err++;
            $display("FAIL hit_308: got %b want 0", sprite_pixel_hit);
        end
        px = 300; py = 100;
        step();
        n_cmp++;
        if (sprite_pixel_hit !== 1'b1) begin
            n_err++;
            $display("FAIL hit_300: got %b want 1", sprite_pixel_hit);
        end
        px = 299;
        step();
        n_cmp++;
        if (sprite_pixel_hit !== 1'b0) begin
            n_err++;
            $display("FAIL hit_299: got %b want 0", sprite_pixel_hit);
        end
    endtask

    task automatic test_reset_mid();
        load(200, 200, 2'b01, 2'b01);
        en = 1;
        step(); step();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (sprite_x !== 0 || sprite_y !== 0 || sprite_pixel_hit !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got %0d,%0d hit=%b want 0,0,0",
                     sprite_x, sprite_y, sprite_pixel_hit);
        end
        do_reset();
        load(10, 10, 2'b01, 2'b01);
        en = 1;
        step(); step();
        n_cmp++;
        if (sprite_x !== 10) begin
            n_err++;
            $display("FAIL phase_early: got x=%0d want 10", sprite_x);
        end
        step();
        n_cmp++;
        if (sprite_x !== 11 || sprite_y !== 11) begin
            n_err++;
            $display("FAIL phase_restart: got %0d,%0d want 11,11", sprite_x, sprite_y);
        end
        en = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wxy  = ($urandom_range(0, 9) == 0);
            wx   = 10'($urandom_range(0, 1) ? $urandom_range(625, 640) : $urandom_range(0, 1023));
            wy   = 10'($urandom_range(0, 1) ? $urandom_range(0, 4) : $urandom_range(465, 480));
            wdxy = ($urandom_range(0, 4) == 0);
            wdx  = 2'($urandom);
            wdy  = 2'($urandom);
            en   = ($urandom_range(0, 4) != 0);
            px   = 10'(wrap(mx + int'($urandom_range(0, 10)) - 1));
            py   = 10'(wrap(my + int'($urandom_range(0, 10)) - 1));
            step();
            n_cmp++;
            if (sprite_x !== 10'(mx) || sprite_y !== 10'(my)) begin
                n_err++;
                $display("FAIL rand_pos: got %0d,%0d want %0d,%0d",
                         sprite_x, sprite_y, mx, my);
            end
            n_cmp++;
            if (sprite_within_screen !== m_within() || sprite_pixel_hit !== mhit) begin
                n_err++;
                $display("FAIL rand_flags: got win=%b hit=%b want win=%b hit=%b",
                         sprite_within_screen, sprite_pixel_hit, m_within(), mhit);
            end
        end
        wxy = 0; wdxy = 0; en = 0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_motion();
        test_right_edge();
        test_wrap();
        test_write_priority();
        test_pixel_hit();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
